// File: rtl/isa_pkg.sv
// ISA constants shared by the decode stage: opcode values, instruction field
// positions and default datapath sizes.
package isa_pkg;

    localparam int DATA_W  = 8;
    localparam int NREG    = 8;
    localparam int INSTR_W = 8;

    typedef enum logic [1:0] {
        OP_MOV = 2'b00,
        OP_ADD = 2'b01,
        OP_ILL = 2'b10,
        OP_J   = 2'b11
    } opcode_e;

    localparam int OP_HI = 7;
    localparam int OP_LO = 6;
    localparam int RD_HI = 5;
    localparam int RD_LO = 3;
    localparam int RS_HI = 2;
    localparam int RS_LO = 0;

endpackage

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports with write-first
// bypass, one write port, synchronous reset loads R[i] = i.
module register_file
    import isa_pkg::*;
#(
    parameter int DATA_W = isa_pkg::DATA_W,
    parameter int NREG   = isa_pkg::NREG,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [AW-1:0]     ra_addr,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);

    logic [DATA_W-1:0] regs_q [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_q[gi] <= DATA_W'(gi);
                end else if (wb_en && wb_addr == AW'(gi)) begin
                    regs_q[gi] <= wb_data;
                end
            end
        end
    endgenerate

    // A write landing this cycle is forwarded so decode never sees stale data.
    assign ra_data = (wb_en && wb_addr == ra_addr) ? wb_data : regs_q[ra_addr];
    assign rb_data = (wb_en && wb_addr == rb_addr) ? wb_data : regs_q[rb_addr];

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: IF/ID register, field decode, register-file read and the
// ID/EX register feeding execute. Jumps leave decode as non-writing bubbles.
module instruction_decode
    import isa_pkg::*;
#(
    parameter int DATA_W  = isa_pkg::DATA_W,
    parameter int NREG    = isa_pkg::NREG,
    parameter int INSTR_W = isa_pkg::INSTR_W,
    localparam int AW     = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] Instruction_Code,
    input  logic               wb_en,
    input  logic [AW-1:0]      wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               id_valid,
    output logic               alu_add,
    output logic               reg_write,
    output logic               is_jump,
    output logic [AW-1:0]      rd_addr,
    output logic [DATA_W-1:0]  opa_data,
    output logic [DATA_W-1:0]  opb_data,
    output logic               illegal
);

    logic [INSTR_W-1:0] ifid_instr_q;
    logic               ifid_valid_q;

    opcode_e            opcode;
    logic [AW-1:0]      rd_field;
    logic [AW-1:0]      rs_field;
    logic [DATA_W-1:0]  ra_data;
    logic [DATA_W-1:0]  rb_data;

    logic               alu_add_d;
    logic               reg_write_d;
    logic               is_jump_d;
    logic               illegal_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            ifid_instr_q <= Instruction_Code;
            ifid_valid_q <= 1'b1;
        end
    end

    assign opcode   = opcode_e'(ifid_instr_q[OP_HI:OP_LO]);
    assign rd_field = ifid_instr_q[RD_HI:RD_LO];
    assign rs_field = ifid_instr_q[RS_HI:RS_LO];

    register_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ra_addr (rd_field),
        .rb_addr (rs_field),
        .ra_data (ra_data),
        .rb_data (rb_data)
    );

    always_comb begin
        alu_add_d   = 1'b0;
        reg_write_d = 1'b0;
        is_jump_d   = 1'b0;
        illegal_d   = 1'b0;
        if (ifid_valid_q) begin
            unique case (opcode)
                OP_MOV: reg_write_d = 1'b1;
                OP_ADD: begin
                    alu_add_d   = 1'b1;
                    reg_write_d = 1'b1;
                end
                OP_J:   is_jump_d = 1'b1;
                OP_ILL: illegal_d = 1'b1;
            endcase
        end
    end

    // Field and operand values pass through for every valid entry; consumers
    // qualify them with reg_write.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid  <= 1'b0;
            alu_add   <= 1'b0;
            reg_write <= 1'b0;
            is_jump   <= 1'b0;
            illegal   <= 1'b0;
            rd_addr   <= '0;
            opa_data  <= '0;
            opb_data  <= '0;
        end else begin
            id_valid  <= ifid_valid_q;
            alu_add   <= alu_add_d;
            reg_write <= reg_write_d;
            is_jump   <= is_jump_d;
            illegal   <= illegal_d;
            rd_addr   <= ifid_valid_q ? rd_field : '0;
            opa_data  <= ifid_valid_q ? ra_data  : '0;
            opb_data  <= ifid_valid_q ? rb_data  : '0;
        end
    end

endmodule
